// File: rtl/rf_cmd_sched.sv
// rf_cmd_sched: queues write/read requests in two 2-entry FIFOs and issues one
// register-file operation per cycle with round-robin arbitration.
module rf_cmd_sched (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_req_valid,
    output logic       wr_req_ready,
    input  logic [2:0] wr_req_addr,
    input  logic [7:0] wr_req_data,
    input  logic       rd_req_valid,
    output logic       rd_req_ready,
    input  logic [2:0] rd_req_addr,
    output logic       rf_wr,
    output logic       rf_rd,
    output logic [2:0] rf_addr,
    output logic [7:0] rf_din,
    input  logic [7:0] rf_dout,
    input  logic       rf_error,
    output logic       rsp_valid,
    output logic [2:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       err_sticky
);
    logic [2:0] r_wq_addr [2];
    logic [7:0] r_wq_data [2];
    logic       r_wq_wp, r_wq_rp;
    logic [1:0] r_wq_cnt;
    logic [2:0] r_rq_addr [2];
    logic       r_rq_wp, r_rq_rp;
    logic [1:0] r_rq_cnt;
    logic       r_wr_ready, r_rd_ready, r_last_rd;
    logic       r_rf_wr, r_rf_rd, r_rsp_valid, r_err;
    logic [2:0] r_rf_addr, r_rsp_addr;
    logic [7:0] r_rf_din;

    logic       w_wr_push, w_rd_push, w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd;
    logic [2:0] w_wr_addr, w_rd_addr;
    logic [7:0] w_wr_data;
    logic [1:0] w_wq_cnt_nxt, w_rq_cnt_nxt;

    assign w_wr_push = wr_req_valid & r_wr_ready;
    assign w_rd_push = rd_req_valid & r_rd_ready;
    // An empty FIFO lets an arriving request straight into the issue register.
    assign w_wr_pend = (r_wq_cnt != 2'd0) | w_wr_push;
    assign w_rd_pend = (r_rq_cnt != 2'd0) | w_rd_push;
    assign w_wr_addr = (r_wq_cnt != 2'd0) ? r_wq_addr[r_wq_rp] : wr_req_addr;
    assign w_wr_data = (r_wq_cnt != 2'd0) ? r_wq_data[r_wq_rp] : wr_req_data;
    assign w_rd_addr = (r_rq_cnt != 2'd0) ? r_rq_addr[r_rq_rp] : rd_req_addr;
    assign w_grant_wr = w_wr_pend & (~w_rd_pend | r_last_rd);
    assign w_grant_rd = w_rd_pend & ~w_grant_wr;
    assign w_wq_cnt_nxt = r_wq_cnt + {1'b0, w_wr_push} - {1'b0, w_grant_wr};
    assign w_rq_cnt_nxt = r_rq_cnt + {1'b0, w_rd_push} - {1'b0, w_grant_rd};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wq_addr  <= '{default: '0};
            r_wq_data  <= '{default: '0};
            r_wq_wp    <= 1'b0;
            r_wq_rp    <= 1'b0;
            r_wq_cnt   <= 2'd0;
            r_wr_ready <= 1'b0;
        end else begin
            if (w_wr_push) begin
                r_wq_addr[r_wq_wp] <= wr_req_addr;
                r_wq_data[r_wq_wp] <= wr_req_data;
                r_wq_wp            <= ~r_wq_wp;
            end
            if (w_grant_wr)
                r_wq_rp <= ~r_wq_rp;
            r_wq_cnt   <= w_wq_cnt_nxt;
            r_wr_ready <= w_wq_cnt_nxt != 2'd2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rq_addr  <= '{default: '0};
            r_rq_wp    <= 1'b0;
            r_rq_rp    <= 1'b0;
            r_rq_cnt   <= 2'd0;
            r_rd_ready <= 1'b0;
        end else begin
            if (w_rd_push) begin
                r_rq_addr[r_rq_wp] <= rd_req_addr;
                r_rq_wp            <= ~r_rq_wp;
            end
            if (w_grant_rd)
                r_rq_rp <= ~r_rq_rp;
            r_rq_cnt   <= w_rq_cnt_nxt;
            r_rd_ready <= w_rq_cnt_nxt != 2'd2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_rd   <= 1'b1;
            r_rf_wr     <= 1'b0;
            r_rf_rd     <= 1'b0;
            r_rf_addr   <= 3'd0;
            r_rf_din    <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= 3'd0;
            r_err       <= 1'b0;
        end else begin
            r_rf_wr <= w_grant_wr;
            r_rf_rd <= w_grant_rd;
            if (w_grant_wr) begin
                r_rf_addr <= w_wr_addr;
                r_rf_din  <= w_wr_data;
                r_last_rd <= 1'b0;
            end else if (w_grant_rd) begin
                r_rf_addr <= w_rd_addr;
                r_last_rd <= 1'b1;
            end
            r_rsp_valid <= r_rf_rd;
            if (r_rf_rd)
                r_rsp_addr <= r_rf_addr;
            r_err <= r_err | rf_error;
        end
    end

    // The file registers its read data, so the response pairs this cycle's rf_dout with the tag.
    assign rsp_data     = r_rsp_valid ? rf_dout : 8'd0;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_addr     = r_rsp_addr;
    assign rf_wr        = r_rf_wr;
    assign rf_rd        = r_rf_rd;
    assign rf_addr      = r_rf_addr;
    assign rf_din       = r_rf_din;
    assign wr_req_ready = r_wr_ready;
    assign rd_req_ready = r_rd_ready;
    assign err_sticky   = r_err;
endmodule

// File: tb/tb_rf_cmd_sched.sv
// tb_rf_cmd_sched: directed checks of rf_cmd_sched against a small registered
// register-file model and hand-computed expectations.
module tb_rf_cmd_sched;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_req_valid = 1'b0, wr_req_ready;
    logic [2:0] wr_req_addr = 3'd0;
    logic [7:0] wr_req_data = 8'd0;
    logic       rd_req_valid = 1'b0, rd_req_ready;
    logic [2:0] rd_req_addr = 3'd0;
    logic       rf_wr, rf_rd;
    logic [2:0] rf_addr;
    logic [7:0] rf_din;
    logic [7:0] rf_dout;
    logic       rf_error = 1'b0;
    logic       rsp_valid;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       err_sticky;
    logic [7:0] mem [8];
    int errors = 0;
    int checks = 0;

    rf_cmd_sched dut (
        .clk(clk), .resetn(resetn),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_addr(rf_addr), .rf_din(rf_din),
        .rf_dout(rf_dout), .rf_error(rf_error),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Register file with registered read data.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'd0;
            rf_dout <= 8'd0;
        end else begin
            if (rf_wr) mem[rf_addr] <= rf_din;
            if (rf_rd) rf_dout <= mem[rf_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL rst_rf_wr: got %b want 0", rf_wr); end
        checks++; if (rf_rd !== 1'b0) begin errors++; $display("FAIL rst_rf_rd: got %b want 0", rf_rd); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_sticky); end
        checks++; if ({wr_req_ready, rd_req_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {wr_req_ready, rd_req_ready}); end
        resetn = 1'b1;
        step();
        checks++; if ({wr_req_ready, rd_req_ready} !== 2'b11) begin errors++; $display("FAIL rel_ready: got %b want 11", {wr_req_ready, rd_req_ready}); end
    endtask

    task automatic test_simultaneous();
        wr_req_valid = 1'b1; wr_req_addr = 3'd1; wr_req_data = 8'h77;
        rd_req_valid = 1'b1; rd_req_addr = 3'd2;
        step();
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        checks++; if ({rf_wr, rf_rd} !== 2'b10) begin errors++; $display("FAIL sim_c1_en: got %b want 10", {rf_wr, rf_rd}); end
        checks++; if ({rf_addr, rf_din} !== {3'd1, 8'h77}) begin errors++; $display("FAIL sim_c1_ad: got %h/%h want 1/77", rf_addr, rf_din); end
        step();
        checks++; if ({rf_wr, rf_rd} !== 2'b01) begin errors++; $display("FAIL sim_c2_en: got %b want 01", {rf_wr, rf_rd}); end
        checks++; if (rf_addr !== 3'd2) begin errors++; $display("FAIL sim_c2_addr: got %h want 2", rf_addr); end
        step();
        checks++; if ({rf_wr, rf_rd} !== 2'b00) begin errors++; $display("FAIL sim_c3_en: got %b want 00", {rf_wr, rf_rd}); end
        checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd2, 8'h00}) begin errors++; $display("FAIL sim_rsp: got %b/%h/%h want 1/2/00", rsp_valid, rsp_addr, rsp_data); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sim_rsp_once: got %b want 0", rsp_valid); end
    endtask

    task automatic test_single_write();
        wr_req_valid = 1'b1; wr_req_addr = 3'd3; wr_req_data = 8'hA5;
        step();
        wr_req_valid = 1'b0;
        checks++; if ({rf_wr, rf_rd, rf_addr, rf_din} !== {2'b10, 3'd3, 8'hA5}) begin errors++; $display("FAIL sw_issue: got %b%b/%h/%h want 10/3/a5", rf_wr, rf_rd, rf_addr, rf_din); end
        step();
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL sw_once: got %b want 0", rf_wr); end
        checks++; if ({rf_addr, rf_din} !== {3'd3, 8'hA5}) begin errors++; $display("FAIL sw_hold: got %h/%h want 3/a5", rf_addr, rf_din); end
    endtask

    task automatic test_write_read();
        wr_req_valid = 1'b1; wr_req_addr = 3'd5; wr_req_data = 8'h3C;
        step();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 3'd5;
        checks++; if ({rf_wr, rf_addr, rf_din} !== {1'b1, 3'd5, 8'h3C}) begin errors++; $display("FAIL wr_issue: got %b/%h/%h want 1/5/3c", rf_wr, rf_addr, rf_din); end
        step();
        rd_req_valid = 1'b0;
        checks++; if ({rf_wr, rf_rd, rf_addr} !== {2'b01, 3'd5}) begin errors++; $display("FAIL rd_issue: got %b%b/%h want 01/5", rf_wr, rf_rd, rf_addr); end
        checks++; if (rf_din !== 8'h3C) begin errors++; $display("FAIL rd_din_hold: got %h want 3c", rf_din); end
        step();
        checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd5, 8'h3C}) begin errors++; $display("FAIL wr_rd_rsp: got %b/%h/%h want 1/5/3c", rsp_valid, rsp_addr, rsp_data); end
        checks++; if (rf_rd !== 1'b0) begin errors++; $display("FAIL rd_once: got %b want 0", rf_rd); end
        step();
        checks++; if ({rsp_valid, rsp_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL rsp_drop: got %b/%h want 0/00", rsp_valid, rsp_data); end
    endtask

    task automatic test_fill();
        wr_req_valid = 1'b1; wr_req_addr = 3'd7; wr_req_data = 8'h10;
        rd_req_valid = 1'b1; rd_req_addr = 3'd3;
        step();
        wr_req_data = 8'h11; rd_req_addr = 3'd5;
        checks++; if ({rf_wr, rf_rd, rf_din} !== {2'b10, 8'h10}) begin errors++; $display("FAIL fill_e1: got %b%b/%h want 10/10", rf_wr, rf_rd, rf_din); end
        step();
        wr_req_data = 8'h12; rd_req_addr = 3'd1;
        checks++; if ({rf_wr, rf_rd, rf_addr} !== {2'b01, 3'd3}) begin errors++; $display("FAIL fill_e2: got %b%b/%h want 01/3", rf_wr, rf_rd, rf_addr); end
        step();
        wr_req_data = 8'h13; rd_req_valid = 1'b0;
        checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", rd_req_ready); end
        checks++; if ({rf_wr, rf_rd, rf_din} !== {2'b10, 8'h11}) begin errors++; $display("FAIL fill_e3: got %b%b/%h want 10/11", rf_wr, rf_rd, rf_din); end
        checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd3, 8'hA5}) begin errors++; $display("FAIL fill_rsp0: got %b/%h/%h want 1/3/a5", rsp_valid, rsp_addr, rsp_data); end
        step();
        wr_req_valid = 1'b0;
        checks++; if ({rf_wr, rf_rd, rf_addr} !== {2'b01, 3'd5}) begin errors++; $display("FAIL fill_e4: got %b%b/%h want 01/5", rf_wr, rf_rd, rf_addr); end
        checks++; if ({wr_req_ready, rd_req_ready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL fill_e4_rdy: got %b want 010", {wr_req_ready, rd_req_ready, rsp_valid}); end
        step();
        checks++; if ({rf_wr, rf_rd, rf_din} !== {2'b10, 8'h12}) begin errors++; $display("FAIL fill_e5: got %b%b/%h want 10/12", rf_wr, rf_rd, rf_din); end
        checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd5, 8'h3C}) begin errors++; $display("FAIL fill_rsp1: got %b/%h/%h want 1/5/3c", rsp_valid, rsp_addr, rsp_data); end
        step();
        checks++; if ({rf_wr, rf_rd, rf_addr, rsp_valid} !== {2'b01, 3'd1, 1'b0}) begin errors++; $display("FAIL fill_e6: got %b%b/%h/%b want 01/1/0", rf_wr, rf_rd, rf_addr, rsp_valid); end
        step();
        checks++; if ({rf_wr, rf_rd, rf_addr, rf_din} !== {2'b10, 3'd7, 8'h13}) begin errors++; $display("FAIL fill_e7: got %b%b/%h/%h want 10/7/13", rf_wr, rf_rd, rf_addr, rf_din); end
        checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd1, 8'h77}) begin errors++; $display("FAIL fill_rsp2: got %b/%h/%h want 1/1/77", rsp_valid, rsp_addr, rsp_data); end
        step();
        checks++; if ({rf_wr, rf_rd, rsp_valid} !== 3'b000) begin errors++; $display("FAIL fill_idle: got %b want 000", {rf_wr, rf_rd, rsp_valid}); end
    endtask

    task automatic test_error();
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", err_sticky); end
        rf_error = 1'b1;
        step();
        rf_error = 1'b0;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_sticky); end
        repeat (3) step();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_hold: got %b want 1", err_sticky); end
    endtask

    task automatic test_reset_inflight();
        rd_req_valid = 1'b1; rd_req_addr = 3'd5;
        step();
        rd_req_valid = 1'b0;
        checks++; if ({rf_rd, rf_addr} !== {1'b1, 3'd5}) begin errors++; $display("FAIL inf_issue: got %b/%h want 1/5", rf_rd, rf_addr); end
        #3 resetn = 1'b0;
        #1;
        checks++; if ({rf_wr, rf_rd, rf_addr, rf_din} !== 13'd0) begin errors++; $display("FAIL inf_rf_zero: got %b%b/%h/%h want 00/0/00", rf_wr, rf_rd, rf_addr, rf_din); end
        checks++; if ({rsp_valid, rsp_addr, rsp_data, err_sticky} !== 13'd0) begin errors++; $display("FAIL inf_rsp_zero: got %b/%h/%h/%b want 0/0/00/0", rsp_valid, rsp_addr, rsp_data, err_sticky); end
        checks++; if ({wr_req_ready, rd_req_ready} !== 2'b00) begin errors++; $display("FAIL inf_ready: got %b want 00", {wr_req_ready, rd_req_ready}); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inf_no_rsp: got %b want 0", rsp_valid); end
        resetn = 1'b1;
        #1;
        checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL inf_ready_early: got %b want 0", rd_req_ready); end
        step();
        checks++; if ({wr_req_ready, rd_req_ready, rsp_valid} !== 3'b110) begin errors++; $display("FAIL inf_release: got %b want 110", {wr_req_ready, rd_req_ready, rsp_valid}); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inf_no_rsp2: got %b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_write();
        test_write_read();
        test_fill();
        test_error();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
